// File: rtl/ei_sched_pkg.sv
// Shared types and helpers for the external-interrupt tick scheduler.
package ei_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } ei_state_t;

  // Source-ID width; at least one bit so a single source still has a port.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ei_tick_divider.sv
// Fixed-period tick divider: one-cycle tick every PERIOD+1 enabled cycles.
module ei_tick_divider #(
  parameter int               CNT_W  = 16,
  parameter logic [CNT_W-1:0] PERIOD = '0
) (
  input  logic clk,
  input  logic resetb,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal-count compare and wrap; a disabled divider parks at zero.
  always_comb begin
    tick  = en && (cnt_q == PERIOD);
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ei_tick_scheduler.sv
// Shares one external interrupt line between N_SRC periodic tick sources.
// Each source latches a pending bit; a round-robin FSM grants one at a time
// and firmware acknowledges with a rising edge on ack_lvl.
module ei_tick_scheduler
  import ei_sched_pkg::*;
#(
  parameter int                            N_SRC   = 2,
  parameter int                            CNT_W   = 16,
  parameter logic [N_SRC-1:0][CNT_W-1:0]   PERIODS = {16'd39999, 16'd6249},
  localparam int                           SRC_W   = src_w(N_SRC)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [N_SRC-1:0] enable,
  input  logic             ack_lvl,
  input  logic             clear_ovr,
  output logic             ei_req,
  output logic [SRC_W-1:0] ei_src,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  logic [N_SRC-1:0] tick;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] ovr_q, ovr_d;
  logic             ack_q, ack_d, ack_rise;
  ei_state_t        state_q, state_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             req_q, req_d;
  logic             win_found;
  logic [SRC_W-1:0] win_idx;
  int               idx;

  for (genvar i = 0; i < N_SRC; i++) begin : g_div
    ei_tick_divider #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIODS[i])
    ) u_div (
      .clk    (clk),
      .resetb (resetb),
      .en     (enable[i]),
      .tick   (tick[i])
    );
  end

  // Ack edge detect; only an edge seen while granting clears a source.
  always_comb begin
    ack_d    = ack_lvl;
    ack_rise = ack_lvl & ~ack_q;
    clr      = '0;
    if (state_q == GRANT && ack_rise) clr[src_q] = 1'b1;
  end

  // Pending/overrun update: a tick beats a same-cycle clear and then is
  // not an overrun, since the previous event was just serviced.
  always_comb begin
    pend_d = '0;
    ovr_d  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pend_d[i] = enable[i] & (tick[i] | (pend_q[i] & ~clr[i]));
      ovr_d[i]  = (tick[i] & pend_q[i] & ~clr[i]) | (ovr_q[i] & ~clear_ovr);
    end
  end

  // Round-robin pick: first pending source at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_q) + k) % N_SRC;
      if (!win_found && pend_q[idx]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(idx);
      end
    end
  end

  // Grant FSM; RELEASE waits for ack low so a held ack never re-grants.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          src_d   = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack_rise) begin
          rr_d    = (int'(src_q) == N_SRC - 1) ? '0 : src_q + 1'b1;
          state_d = RELEASE;
        end else if (!enable[src_q]) begin
          // Disabling the source already dropped its pending bit.
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!ack_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == GRANT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ei_req  = req_q;
  assign ei_src  = src_q;
  assign pending = pend_q;
  assign overrun = ovr_q;

endmodule
